universal_barrel_shifter: RTL and testbench



---
 rtl/universal_barrel_shifter_pkg.sv | 25 ++
 rtl/barrel_shift_right_core.sv | 30 +++
 rtl/universal_barrel_shifter.sv | 60 ++++++
 tb/tb_universal_barrel_shifter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/universal_barrel_shifter_pkg.sv
// ==== universal_barrel_shifter_pkg : shared sizes, direction codes, bit reversal (rev 1.0) ====
`default_nettype none

package universal_barrel_shifter_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int SHW_DEF   = 4;
  localparam int REV_MAX   = 64;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Reverses all REV_MAX bits; callers shift the result down to their own width.
  function automatic logic [REV_MAX-1:0] bit_reverse(input logic [REV_MAX-1:0] v);
    logic [REV_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < REV_MAX; i++) begin
      r[REV_MAX-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/barrel_shift_right_core.sv
// ==== barrel_shift_right_core : combinational log-stage zero-filling right shifter (rev 1.0) ====
`default_nettype none

module barrel_shift_right_core #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] shifted
);

  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      logic [WIDTH-1:0] w_in;
      logic [WIDTH-1:0] w_out;
      if (k == 0) begin : g_first
        assign w_in = data;
      end else begin : g_next
        assign w_in = g_stage[k-1].w_out;
      end
      assign w_out = amount[k] ? (w_in >> (2 ** k)) : w_in;
    end
  endgenerate

  assign shifted = g_stage[SHW-1].w_out;

endmodule

`default_nettype wire

// File: rtl/universal_barrel_shifter.sv
// ==== universal_barrel_shifter : registered logical left/right barrel shifter (rev 1.0) ====
`default_nettype none

module universal_barrel_shifter
  import universal_barrel_shifter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shift,
  input  logic             shift_choice,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_a_rev;
  logic [WIDTH-1:0] w_core_in;
  logic [WIDTH-1:0] w_core_out;
  logic [WIDTH-1:0] w_core_rev;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic             out_valid_q;

  // Left shift = reverse, shift right, reverse back.
  assign w_a_rev    = WIDTH'(bit_reverse(REV_MAX'(a)) >> (REV_MAX - WIDTH));
  assign w_core_rev = WIDTH'(bit_reverse(REV_MAX'(w_core_out)) >> (REV_MAX - WIDTH));
  assign w_core_in  = (shift_choice == DIR_LEFT) ? w_a_rev : a;
  assign out_d      = (shift_choice == DIR_LEFT) ? w_core_rev : w_core_out;

  barrel_shift_right_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .data    (w_core_in),
    .amount  (shift),
    .shifted (w_core_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q <= out_d;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_universal_barrel_shifter.sv
// ==== tb_universal_barrel_shifter : randomized bench with behavioural shift model (rev 1.0) ====
`default_nettype none

module tb_universal_barrel_shifter;

  localparam int c_WIDTH = 16;
  localparam int c_SHW   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic [c_WIDTH-1:0] a = '0;
  logic [c_SHW-1:0]   shift = '0;
  logic               shift_choice = 1'b0;
  logic [c_WIDTH-1:0] out;
  logic               out_valid;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [c_WIDTH-1:0] m_out;
  logic               m_valid;

  universal_barrel_shifter #(.WIDTH(c_WIDTH), .SHW(c_SHW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .a            (a),
    .shift        (shift),
    .shift_choice (shift_choice),
    .out          (out),
    .out_valid    (out_valid)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: multiply/divide by a power of two, truncated to the width.
  function automatic logic [c_WIDTH-1:0] ref_shift(input logic [c_WIDTH-1:0] v, input int s, input logic right);
    longint unsigned x;
    x = longint'(v);
    if (right) x = x / (64'd1 << s);
    else       x = (x * (64'd1 << s)) % (64'd1 << c_WIDTH);
    return x[c_WIDTH-1:0];
  endfunction

  task automatic check(input string name, input logic [c_WIDTH-1:0] act, input logic [c_WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_out   = '0;
      m_valid = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) m_out = ref_shift(a, int'(shift), shift_choice);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_out", out, m_out);
      check("model_valid", {15'd0, out_valid}, {15'd0, m_valid});
    end
  end

  task automatic drive(input logic v, input logic [c_WIDTH-1:0] av, input int s, input logic dir);
    in_valid     = v;
    a            = av;
    shift        = c_SHW'(s);
    shift_choice = dir;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input string name, input logic [c_WIDTH-1:0] exp_out, input logic exp_v);
    check({name, "_out"}, out, exp_out);
    check({name, "_valid"}, {15'd0, out_valid}, {15'd0, exp_v});
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 16'h1234, 0, 1'b0);
    chk_en = 1'b1;
    drive(1'b1, 16'h1234, 0, 1'b0);
    expect_lit("reset", 16'h0000, 1'b0);
    rst = 1'b0;

    drive(1'b1, 16'd45650, 3, 1'b0); expect_lit("left3", 16'd37520, 1'b1);
    drive(1'b1, 16'd45650, 3, 1'b1); expect_lit("right3", 16'd5706, 1'b1);
    drive(1'b1, 16'hFFFF, 0, 1'b0);  expect_lit("left0", 16'hFFFF, 1'b1);
    drive(1'b1, 16'hFFFF, 0, 1'b1);  expect_lit("right0", 16'hFFFF, 1'b1);
    drive(1'b1, 16'hFFFF, 15, 1'b0); expect_lit("left15", 16'h8000, 1'b1);
    drive(1'b1, 16'hFFFF, 15, 1'b1); expect_lit("right15", 16'h0001, 1'b1);

    rst = 1'b1;
    drive(1'b1, 16'h1234, 4, 1'b1); expect_lit("rst_prio", 16'h0000, 1'b0);
    rst = 1'b0;
    drive(1'b1, 16'h1234, 4, 1'b1); expect_lit("after_rst", 16'h0123, 1'b1);

    drive(1'b1, 16'h0001, 15, 1'b0); expect_lit("b2b_1", 16'h8000, 1'b1);
    drive(1'b1, 16'h8000, 15, 1'b1); expect_lit("b2b_2", 16'h0001, 1'b1);
    drive(1'b0, 16'hABCD, 7, 1'b0);  expect_lit("hold", 16'h0001, 1'b0);

    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 16; s++) begin
        for (int r = 0; r < 4; r++) begin
          drive(1'b1, c_WIDTH'($urandom), s, d[0]);
        end
      end
    end

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) == 0);
      drive(($urandom_range(0, 3) != 0), c_WIDTH'($urandom),
            int'($urandom_range(0, 15)), 1'($urandom));
    end
    rst = 1'b0;
    drive(1'b0, 16'h0000, 0, 1'b0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
